// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multicycle ARM main controller: state codes,
// datapath mux encodings, instruction-class Op codes and the control bundle.
package mainfsm_pkg;

  // 4-bit state codes; 11..15 are illegal and recover to FETCH.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_UNKNOWN  = 4'd10;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_EXT  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Instruction class from Instr[27:26].
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Per-cycle control bundle driven by the output decode.
  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  // True for the final state of an instruction that retires (UNKNOWN does not).
  function automatic logic is_retire_state(input logic [3:0] st);
    logic r;
    case (st)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mainfsm_ctr.sv
// 32-bit enabled up-counter with asynchronous active-high reset; wraps naturally.
module mainfsm_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] q
);

  // Count register: clear on reset, advance by one when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 32'd0;
    end else if (en) begin
      q <= q + 32'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/mainfsm.sv
// Moore main control FSM of the multicycle ARM controller. Write requests
// (RegW, MemW, Branch) are unconditional here; condition gating happens
// downstream. Also counts retired instructions for bring-up.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        ALUOp,
  output logic        NextPC,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic [3:0]  State,
  output logic [31:0] InstrCount
);

  logic [3:0] state;
  logic [3:0] next_state;
  ctrl_t      ctrl;
  logic       retire;

  // Only I (bit 5) and S/L (bit 0) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register; reset forces FETCH immediately so pending writes drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; Op/Funct are only consulted in DECODE and MEMADR.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        if (Funct[0]) begin
          next_state = S_MEMRD;
        end else begin
          next_state = S_MEMWR;
        end
      end
      S_MEMRD:    next_state = S_MEMWB;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode: a pure function of the current state.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      S_MEMADR: ctrl.alu_src_b = SRCB_EXT;
      S_MEMRD:  ctrl.adr_src   = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECUTER: ctrl.alu_op = 1'b1;
      S_EXECUTEI: begin
        ctrl.alu_src_b = SRCB_EXT;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: ctrl.reg_w = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_b  = SRCB_EXT;
        ctrl.result_src = RES_ALURES;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign State     = state;

  // Retirement: leaving a completing state for FETCH (UNKNOWN/illegal excluded).
  assign retire = is_retire_state(state) && (next_state == S_FETCH);

  mainfsm_ctr u_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .q     (InstrCount)
  );

endmodule

// File: tb/tb_mainfsm.sv
// Directed self-checking bench for mainfsm: per-instruction state sequences,
// per-state control outputs, retire counting, mid-instruction reset and wrap.
module tb_mainfsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  Op = 2'b00;
  logic [5:0]  Funct = 6'b000000;
  logic        IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  int vecs = 0;
  int miscompares = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .State(State), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
  wire [11:0] ctrl_obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                          ALUOp, NextPC, RegW, MemW, Branch};

  // Hand-written control table per state code.
  function automatic logic [11:0] exp_ctrl(input int st);
    case (st)
      0:       return 12'b1_0_1_10_10_0_1_0_0_0;
      1:       return 12'b0_0_1_10_10_0_0_0_0_0;
      2:       return 12'b0_0_0_01_00_0_0_0_0_0;
      3:       return 12'b0_1_0_00_00_0_0_0_0_0;
      4:       return 12'b0_0_0_00_01_0_0_1_0_0;
      5:       return 12'b0_1_0_00_00_0_0_0_1_0;
      6:       return 12'b0_0_0_00_00_1_0_0_0_0;
      7:       return 12'b0_0_0_01_00_1_0_0_0_0;
      8:       return 12'b0_0_0_00_00_0_0_1_0_0;
      9:       return 12'b0_0_0_01_10_0_0_0_0_1;
      default: return 12'b0;
    endcase
  endfunction

  task automatic test_reset();
    int seq [5] = '{0, 1, 6, 8, 0};
    reset = 1'b1; Op = 2'b00; Funct = 6'b000000;
    @(negedge clk); @(negedge clk);
    vecs++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || ctrl_obs !== exp_ctrl(0)) begin
      miscompares++;
      $display("FAIL reset_state: got state=%0d cnt=%0d ctrl=%b expected state=0 cnt=0 ctrl=%b",
               State, InstrCount, ctrl_obs, exp_ctrl(0));
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vecs++;
      if (State !== 4'(seq[i]) || ctrl_obs !== exp_ctrl(seq[i])) begin
        miscompares++;
        $display("FAIL dp_reg step %0d: got state=%0d ctrl=%b expected state=%0d ctrl=%b",
                 i, State, ctrl_obs, seq[i], exp_ctrl(seq[i]));
      end
    end
    vecs++;
    if (InstrCount !== 32'd1) begin
      miscompares++;
      $display("FAIL dp_reg_count: got %0d expected 1", InstrCount);
    end
  endtask

  task automatic test_load();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    Op = 2'b01; Funct = 6'b011001;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      vecs++;
      if (State !== 4'(seq[i]) || ctrl_obs !== exp_ctrl(seq[i])) begin
        miscompares++;
        $display("FAIL load step %0d: got state=%0d ctrl=%b expected state=%0d ctrl=%b",
                 i, State, ctrl_obs, seq[i], exp_ctrl(seq[i]));
      end
    end
    vecs++;
    if (InstrCount !== 32'd2) begin
      miscompares++;
      $display("FAIL load_count: got %0d expected 2", InstrCount);
    end
  endtask

  task automatic test_store();
    int seq [5] = '{0, 1, 2, 5, 0};
    Op = 2'b01; Funct = 6'b011000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vecs++;
      if (State !== 4'(seq[i]) || ctrl_obs !== exp_ctrl(seq[i])) begin
        miscompares++;
        $display("FAIL store step %0d: got state=%0d ctrl=%b expected state=%0d ctrl=%b",
                 i, State, ctrl_obs, seq[i], exp_ctrl(seq[i]));
      end
    end
    vecs++;
    if (InstrCount !== 32'd3) begin
      miscompares++;
      $display("FAIL store_count: got %0d expected 3", InstrCount);
    end
  endtask

  task automatic test_back_to_back();
    int seq_i [5] = '{0, 1, 7, 8, 0};
    int seq_b [4] = '{0, 1, 9, 0};
    Op = 2'b00; Funct = 6'b101000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vecs++;
      if (State !== 4'(seq_i[i]) || ctrl_obs !== exp_ctrl(seq_i[i])) begin
        miscompares++;
        $display("FAIL dp_imm step %0d: got state=%0d ctrl=%b expected state=%0d ctrl=%b",
                 i, State, ctrl_obs, seq_i[i], exp_ctrl(seq_i[i]));
      end
    end
    Op = 2'b10; Funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vecs++;
      if (State !== 4'(seq_b[i]) || ctrl_obs !== exp_ctrl(seq_b[i])) begin
        miscompares++;
        $display("FAIL branch step %0d: got state=%0d ctrl=%b expected state=%0d ctrl=%b",
                 i, State, ctrl_obs, seq_b[i], exp_ctrl(seq_b[i]));
      end
    end
    vecs++;
    if (InstrCount !== 32'd5) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected 5", InstrCount);
    end
  endtask

  task automatic test_undefined();
    int seq [4] = '{0, 1, 10, 0};
    Op = 2'b11; Funct = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vecs++;
      if (State !== 4'(seq[i]) || ctrl_obs !== exp_ctrl(seq[i])) begin
        miscompares++;
        $display("FAIL undef step %0d: got state=%0d ctrl=%b expected state=%0d ctrl=%b",
                 i, State, ctrl_obs, seq[i], exp_ctrl(seq[i]));
      end
    end
    vecs++;
    if (InstrCount !== 32'd5) begin
      miscompares++;
      $display("FAIL undef_count: got %0d expected 5", InstrCount);
    end
  endtask

  task automatic test_mid_reset();
    Op = 2'b01; Funct = 6'b011000;
    repeat (3) @(negedge clk);
    vecs++;
    if (State !== 4'd5 || MemW !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got state=%0d MemW=%b expected state=5 MemW=1", State, MemW);
    end
    #1 reset = 1'b1;
    #1;
    vecs++;
    if (MemW !== 1'b0 || State !== 4'd0 || InstrCount !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_post: got MemW=%b state=%0d cnt=%0d expected MemW=0 state=0 cnt=0",
               MemW, State, InstrCount);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    Op = 2'b00; Funct = 6'b000000;
    force dut.u_ctr.q = 32'hFFFF_FFFF;
    #1 release dut.u_ctr.q;
    vecs++;
    if (InstrCount !== 32'hFFFF_FFFF || State !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_preload: got cnt=%h state=%0d expected cnt=ffffffff state=0",
               InstrCount, State);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (InstrCount !== 32'hFFFF_FFFF || State !== 4'd8) begin
      miscompares++;
      $display("FAIL wrap_hold: got cnt=%h state=%0d expected cnt=ffffffff state=8",
               InstrCount, State);
    end
    @(negedge clk);
    vecs++;
    if (InstrCount !== 32'd0 || State !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap: got cnt=%h state=%0d expected cnt=00000000 state=0",
               InstrCount, State);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_undefined();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
